// File: rtl/bus_regfile_mux_if.sv
// Bus-side signal bundle for bus_regfile_mux: selects, write enables, data inputs,
// bus/register observation and conflict status.
interface bus_regfile_mux_if #(
    parameter int WIDTH = 9,
    parameter int NREGS = 8,
    parameter int ERRW  = 4
) ();
    logic [WIDTH-1:0]       din;
    logic [WIDTH-1:0]       g_in;
    logic [NREGS-1:0]       rsele;
    logic                   gsele;
    logic                   dsele;
    logic [NREGS-1:0]       rin;
    logic                   err_clr;
    logic [WIDTH-1:0]       bus_out;
    logic [WIDTH-1:0]       bus_q;
    logic [NREGS*WIDTH-1:0] regs_flat;
    logic                   conflict;
    logic                   err_sticky;
    logic [ERRW-1:0]        err_cnt;

    modport master (
        output din, g_in, rsele, gsele, dsele, rin, err_clr,
        input  bus_out, bus_q, regs_flat, conflict, err_sticky, err_cnt
    );

    modport slave (
        input  din, g_in, rsele, gsele, dsele, rin, err_clr,
        output bus_out, bus_q, regs_flat, conflict, err_sticky, err_cnt
    );
endinterface

// File: rtl/bus_regfile_mux.sv
// Register file plus priority bus multiplexer (G > Din > R0..R(N-1)) with
// select-conflict detection, optional strict blocking and a saturating error counter.
module bus_regfile_mux #(
    parameter int WIDTH  = 9,
    parameter int NREGS  = 8,
    parameter bit STRICT = 1'b0,
    parameter int ERRW   = 4
) (
    input  logic          clk,
    input  logic          reset,
    bus_regfile_mux_if.slave bus
);
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_bus_q;
    logic             r_err_sticky;
    logic [ERRW-1:0]  r_err_cnt;

    logic [WIDTH-1:0] w_bus_prio;
    logic [WIDTH-1:0] w_bus;
    logic             w_rsel_multi;
    logic             w_conflict;
    logic             w_block;

    assign w_rsel_multi = (bus.rsele & (bus.rsele - NREGS'(1))) != '0;
    assign w_conflict   = (bus.gsele & bus.dsele)
                        | ((bus.gsele | bus.dsele) & (|bus.rsele))
                        | w_rsel_multi;
    assign w_block      = STRICT && w_conflict;

    // Scan from the top down so the lowest-indexed selected register wins.
    always_comb begin
        w_bus_prio = '0;
        if (bus.gsele) begin
            w_bus_prio = bus.g_in;
        end else if (bus.dsele) begin
            w_bus_prio = bus.din;
        end else begin
            for (int i = NREGS - 1; i >= 0; i--) begin
                if (bus.rsele[i]) begin
                    w_bus_prio = r_regs[i];
                end
            end
        end
    end

    assign w_bus = w_block ? '0 : w_bus_prio;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_bus_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (bus.rin[i] && !w_block) begin
                    r_regs[i] <= w_bus;
                end
            end
            r_bus_q <= w_bus;
        end
    end

    // err_clr outranks a simultaneous conflict.
    always_ff @(posedge clk) begin
        if (reset || bus.err_clr) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else if (w_conflict) begin
            r_err_sticky <= 1'b1;
            if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + ERRW'(1);
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign bus.regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
    end

    assign bus.bus_out    = w_bus;
    assign bus.bus_q      = r_bus_q;
    assign bus.conflict   = w_conflict;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_bus_regfile_mux.sv
// Scoreboard bench for bus_regfile_mux: one priority instance and one strict
// instance driven with identical stimulus.
module tb_bus_regfile_mux;
    localparam int WIDTH = 9;
    localparam int NREGS = 8;
    localparam int ERRW  = 4;

    localparam int K_BUS  = 0;
    localparam int K_BUSQ = 1;
    localparam int K_REG  = 2;
    localparam int K_CONF = 3;
    localparam int K_STK  = 4;
    localparam int K_CNT  = 5;

    typedef struct {
        string       tag;
        bit          dut;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } sb_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    sb_t  q_now[$];
    sb_t  q_next[$];

    bus_regfile_mux_if #(.WIDTH(WIDTH), .NREGS(NREGS), .ERRW(ERRW)) if0 ();
    bus_regfile_mux_if #(.WIDTH(WIDTH), .NREGS(NREGS), .ERRW(ERRW)) if1 ();

    bus_regfile_mux #(.WIDTH(WIDTH), .NREGS(NREGS), .STRICT(1'b0), .ERRW(ERRW)) u_prio (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    bus_regfile_mux #(.WIDTH(WIDTH), .NREGS(NREGS), .STRICT(1'b1), .ERRW(ERRW)) u_strict (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input bit dut, input int kind, input int idx);
        logic [31:0] v;
        v = '0;
        case (kind)
            K_BUS:  v = dut ? 32'(if1.bus_out)    : 32'(if0.bus_out);
            K_BUSQ: v = dut ? 32'(if1.bus_q)      : 32'(if0.bus_q);
            K_REG:  v = dut ? 32'(if1.regs_flat[idx*WIDTH +: WIDTH])
                            : 32'(if0.regs_flat[idx*WIDTH +: WIDTH]);
            K_CONF: v = dut ? 32'(if1.conflict)   : 32'(if0.conflict);
            K_STK:  v = dut ? 32'(if1.err_sticky) : 32'(if0.err_sticky);
            K_CNT:  v = dut ? 32'(if1.err_cnt)    : 32'(if0.err_cnt);
            default: v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    task automatic push(input bit now, input string tag, input bit dut, input int kind,
                        input int idx, input logic [31:0] exp);
        sb_t e;
        e.tag  = $sformatf("%s_d%0d", tag, dut);
        e.dut  = dut;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        if (now) q_now.push_back(e);
        else     q_next.push_back(e);
    endtask

    task automatic drive(input logic g, input logic [WIDTH-1:0] gv, input logic d,
                         input logic [WIDTH-1:0] dv, input logic [NREGS-1:0] rs,
                         input logic [NREGS-1:0] ri, input logic clr, input logic rst);
        reset       = rst;
        if0.gsele   = g;   if1.gsele   = g;
        if0.g_in    = gv;  if1.g_in    = gv;
        if0.dsele   = d;   if1.dsele   = d;
        if0.din     = dv;  if1.din     = dv;
        if0.rsele   = rs;  if1.rsele   = rs;
        if0.rin     = ri;  if1.rin     = ri;
        if0.err_clr = clr; if1.err_clr = clr;
    endtask

    // Compare combinational expectations, clock once, then compare registered ones.
    task automatic step();
        sb_t e;
        #1;
        while (q_now.size() > 0) begin
            e = q_now.pop_front();
            check_val(e.tag, observe(e.dut, e.kind, e.idx), e.exp);
        end
        @(posedge clk);
        #1;
        while (q_next.size() > 0) begin
            e = q_next.pop_front();
            check_val(e.tag, observe(e.dut, e.kind, e.idx), e.exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        @(negedge clk);

        // Reset: everything clears.
        drive(0, '0, 0, '0, '0, '0, 0, 1);
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < NREGS; r++) push(0, $sformatf("rst_r%0d", r), d[0], K_REG, r, 0);
            push(0, "rst_busq", d[0], K_BUSQ, 0, 0);
            push(0, "rst_stk",  d[0], K_STK,  0, 0);
            push(0, "rst_cnt",  d[0], K_CNT,  0, 0);
        end
        step();

        // Din into R2.
        drive(0, '0, 1, 9'h1A5, '0, 8'b0000_0100, 0, 0);
        for (int d = 0; d < 2; d++) begin
            push(1, "ld_bus",  d[0], K_BUS,  0, 9'h1A5);
            push(1, "ld_conf", d[0], K_CONF, 0, 0);
            push(0, "ld_r2",   d[0], K_REG,  2, 9'h1A5);
            push(0, "ld_busq", d[0], K_BUSQ, 0, 9'h1A5);
        end
        step();

        // R2 copied to R0 and R7.
        drive(0, '0, 0, '0, 8'b0000_0100, 8'b1000_0001, 0, 0);
        for (int d = 0; d < 2; d++) begin
            push(1, "cp_bus",  d[0], K_BUS,  0, 9'h1A5);
            push(1, "cp_conf", d[0], K_CONF, 0, 0);
            push(0, "cp_r0",   d[0], K_REG,  0, 9'h1A5);
            push(0, "cp_r7",   d[0], K_REG,  7, 9'h1A5);
            push(0, "cp_r2",   d[0], K_REG,  2, 9'h1A5);
        end
        step();

        // Preload R3 so the strict instance can show it is left alone.
        drive(0, '0, 1, 9'h033, '0, 8'b0000_1000, 0, 0);
        for (int d = 0; d < 2; d++) push(0, "pre_r3", d[0], K_REG, 3, 9'h033);
        step();

        // G and Din both selected, write R3.
        drive(1, 9'h0F0, 1, 9'h111, '0, 8'b0000_1000, 0, 0);
        push(1, "gd_bus",  0, K_BUS,  0, 9'h0F0);
        push(1, "gd_bus",  1, K_BUS,  0, 0);
        push(0, "gd_r3",   0, K_REG,  3, 9'h0F0);
        push(0, "gd_r3",   1, K_REG,  3, 9'h033);
        push(0, "gd_busq", 0, K_BUSQ, 0, 9'h0F0);
        push(0, "gd_busq", 1, K_BUSQ, 0, 0);
        for (int d = 0; d < 2; d++) begin
            push(1, "gd_conf", d[0], K_CONF, 0, 1);
            push(0, "gd_stk",  d[0], K_STK,  0, 1);
            push(0, "gd_cnt",  d[0], K_CNT,  0, 1);
        end
        step();

        // Two register selects: lowest index (R2) wins in priority mode.
        drive(0, '0, 0, '0, 8'b0000_1100, '0, 0, 0);
        push(1, "mr_bus", 0, K_BUS, 0, 9'h1A5);
        push(1, "mr_bus", 1, K_BUS, 0, 0);
        for (int d = 0; d < 2; d++) begin
            push(1, "mr_conf", d[0], K_CONF, 0, 1);
            push(0, "mr_cnt",  d[0], K_CNT,  0, 2);
        end
        step();

        // Saturation: 20 more conflict cycles, counter stops at all-ones.
        for (int k = 1; k <= 20; k++) begin
            drive(1, 9'h001, 1, 9'h002, '0, '0, 0, 0);
            for (int d = 0; d < 2; d++)
                push(0, $sformatf("sat%0d_cnt", k), d[0], K_CNT, 0, (2 + k > 15) ? 15 : 2 + k);
            step();
        end

        // err_clr beats a simultaneous conflict.
        drive(1, 9'h001, 1, 9'h002, '0, '0, 1, 0);
        for (int d = 0; d < 2; d++) begin
            push(1, "clr_conf", d[0], K_CONF, 0, 1);
            push(0, "clr_cnt",  d[0], K_CNT,  0, 0);
            push(0, "clr_stk",  d[0], K_STK,  0, 0);
        end
        step();

        // Load R5, then one conflict cycle so the counter is nonzero before reset.
        drive(0, '0, 1, 9'h155, '0, 8'b0010_0000, 0, 0);
        for (int d = 0; d < 2; d++) push(0, "l5_r5", d[0], K_REG, 5, 9'h155);
        step();
        drive(1, '0, 1, '0, '0, '0, 0, 0);
        for (int d = 0; d < 2; d++) push(0, "pre_cnt", d[0], K_CNT, 0, 1);
        step();

        // Reset with a pending write to R5: the write is discarded.
        drive(0, '0, 1, 9'h0AA, '0, 8'b0010_0000, 0, 1);
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < NREGS; r++) push(0, $sformatf("rs2_r%0d", r), d[0], K_REG, r, 0);
            push(0, "rs2_busq", d[0], K_BUSQ, 0, 0);
            push(0, "rs2_cnt",  d[0], K_CNT,  0, 0);
            push(0, "rs2_stk",  d[0], K_STK,  0, 0);
        end
        step();

        // Reading R5 after reset shows the cleared contents.
        drive(0, '0, 0, '0, 8'b0010_0000, '0, 0, 0);
        for (int d = 0; d < 2; d++) begin
            push(1, "post_bus",  d[0], K_BUS,  0, 0);
            push(1, "post_conf", d[0], K_CONF, 0, 0);
            push(0, "post_busq", d[0], K_BUSQ, 0, 0);
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
